// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: inter-stage bus widths, field offsets and load-size decode.
package mem_stage_pkg;

    localparam int EX_MEM_BUS_W = 108;
    localparam int MEM_WB_BUS_W = 70;
    localparam int MEM_ID_BUS_W = 38;

    // EX->MEM bus field offsets (LSB positions, MSB-first packing)
    localparam int EXB_PC_LSB       = 76;
    localparam int EXB_RES_FROM_MEM = 75;
    localparam int EXB_RF_WE        = 74;
    localparam int EXB_WADDR_LSB    = 69;
    localparam int EXB_ALU_LSB      = 37;
    localparam int EXB_RKD_LSB      = 5;
    localparam int EXB_ADDR_LO_LSB  = 3;
    localparam int EXB_OP_B         = 2;
    localparam int EXB_OP_H         = 1;
    localparam int EXB_OP_U         = 0;

    // MEM->WB / MEM->ID bus field offsets
    localparam int MWB_PC_LSB    = 38;
    localparam int MWB_RF_WE     = 37;
    localparam int MWB_WADDR_LSB = 32;
    localparam int MWB_RES_LSB   = 0;

    typedef enum logic [1:0] {
        LD_WORD = 2'd0,
        LD_HALF = 2'd1,
        LD_BYTE = 2'd2
    } ld_size_e;

    function automatic ld_size_e ld_size(input logic op_b, input logic op_h);
        if (op_b)      return LD_BYTE;
        else if (op_h) return LD_HALF;
        else           return LD_WORD;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational byte/half/word extraction and zero/sign extension of RAM read data.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] eff_rdata,
    input  logic [1:0]  addr_lo,
    input  logic        op_b,
    input  logic        op_h,
    input  logic        op_u,
    output logic [31:0] load_result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select; half loads ignore addr_lo[0] so misaligned halves never trap
    always_comb begin
        byte_s = eff_rdata[7:0];
        case (addr_lo)
            2'd0:    byte_s = eff_rdata[7:0];
            2'd1:    byte_s = eff_rdata[15:8];
            2'd2:    byte_s = eff_rdata[23:16];
            2'd3:    byte_s = eff_rdata[31:24];
            default: byte_s = eff_rdata[7:0];
        endcase
        if (addr_lo[1]) half_s = eff_rdata[31:16];
        else            half_s = eff_rdata[15:0];
    end

    // Size-dependent extension
    always_comb begin
        load_result = eff_rdata;
        case (ld_size(op_b, op_h))
            LD_BYTE: load_result = {{24{~op_u & byte_s[7]}}, byte_s};
            LD_HALF: load_result = {{16{~op_u & half_s[15]}}, half_s};
            LD_WORD: load_result = eff_rdata;
            default: load_result = eff_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: valid/allowin handshake, payload register, load-data capture
// across WB stalls, and result selection for WB and ID forwarding.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ex_to_mem_valid,
    input  logic [EX_MEM_BUS_W-1:0] ex_to_mem_bus,
    output logic                    mem_allowin,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    wb_allowin,
    output logic                    mem_to_wb_valid,
    output logic [MEM_WB_BUS_W-1:0] mem_to_wb_bus,
    output logic [MEM_ID_BUS_W-1:0] mem_to_id_bus
);

    logic                    mem_valid_r;
    logic                    first_cyc_r;
    logic [EX_MEM_BUS_W-1:0] payload_r;
    logic [31:0]             rdata_hold_r;

    logic        mem_ready_go_s;
    logic        accept_s;
    logic [31:0] eff_rdata_s;
    logic [31:0] load_result_s;
    logic [31:0] final_result_s;
    logic        rf_we_s;
    logic        unused_rkd_s;

    assign mem_ready_go_s  = 1'b1;
    assign mem_allowin     = ~mem_valid_r | (wb_allowin & mem_ready_go_s);
    assign mem_to_wb_valid = mem_valid_r & mem_ready_go_s;
    assign accept_s        = ex_to_mem_valid & mem_allowin;

    // Handshake state, payload capture and load-data hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_r  <= 1'b0;
            first_cyc_r  <= 1'b0;
            payload_r    <= {EX_MEM_BUS_W{1'b0}};
            rdata_hold_r <= 32'h0000_0000;
        end else begin
            if (mem_allowin) begin
                mem_valid_r <= ex_to_mem_valid;
            end
            if (accept_s) begin
                payload_r <= ex_to_mem_bus;
            end
            first_cyc_r <= accept_s;
            // RAM data is only valid in the first cycle; keep it for stalled cycles
            if (mem_valid_r & first_cyc_r) begin
                rdata_hold_r <= data_sram_rdata;
            end
        end
    end

    assign eff_rdata_s = first_cyc_r ? data_sram_rdata : rdata_hold_r;

    load_align u_load_align (
        .eff_rdata   (eff_rdata_s),
        .addr_lo     (payload_r[EXB_ADDR_LO_LSB +: 2]),
        .op_b        (payload_r[EXB_OP_B]),
        .op_h        (payload_r[EXB_OP_H]),
        .op_u        (payload_r[EXB_OP_U]),
        .load_result (load_result_s)
    );

    assign final_result_s = payload_r[EXB_RES_FROM_MEM] ? load_result_s
                                                        : payload_r[EXB_ALU_LSB +: 32];
    assign rf_we_s        = payload_r[EXB_RF_WE] & mem_valid_r;
    assign unused_rkd_s   = ^payload_r[EXB_RKD_LSB +: 32];

    assign mem_to_wb_bus = {payload_r[EXB_PC_LSB +: 32], rf_we_s,
                            payload_r[EXB_WADDR_LSB +: 5], final_result_s};
    assign mem_to_id_bus = {rf_we_s, payload_r[EXB_WADDR_LSB +: 5], final_result_s};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed expected values.
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         ex_to_mem_valid;
    logic [107:0] ex_to_mem_bus;
    logic         mem_allowin;
    logic [31:0]  data_sram_rdata;
    logic         wb_allowin;
    logic         mem_to_wb_valid;
    logic [69:0]  mem_to_wb_bus;
    logic [37:0]  mem_to_id_bus;

    int tests_run;
    int tests_failed;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .mem_allowin     (mem_allowin),
        .data_sram_rdata (data_sram_rdata),
        .wb_allowin      (wb_allowin),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [107:0] mk_bus(input logic [31:0] pc, input logic res_mem,
                                            input logic we, input logic [4:0] waddr,
                                            input logic [31:0] alu, input logic [1:0] lo,
                                            input logic b, input logic h, input logic u);
        return {pc, res_mem, we, waddr, alu, 32'hA5A5_A5A5, lo, b, h, u};
    endfunction

    // Accept one payload, present RAM data in its first cycle, check the result
    task automatic do_load(input string tag, input logic [107:0] bus,
                           input logic [31:0] rdata, input logic [31:0] exp);
        @(posedge clk); #1;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = bus;
        @(posedge clk); #1;
        ex_to_mem_valid = 1'b0;
        data_sram_rdata = rdata;
        @(negedge clk);
        chk({tag, "_valid"}, {69'd0, mem_to_wb_valid}, 70'd1);
        chk(tag, {38'd0, mem_to_wb_bus[31:0]}, {38'd0, exp});
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        resetn          = 1'b0;
        ex_to_mem_valid = 1'b0;
        ex_to_mem_bus   = 108'd0;
        data_sram_rdata = 32'd0;
        wb_allowin      = 1'b1;

        #3;
        chk("rst_allowin", {69'd0, mem_allowin}, 70'd1);
        chk("rst_wb_valid", {69'd0, mem_to_wb_valid}, 70'd0);
        chk("rst_wb_bus", mem_to_wb_bus, 70'd0);
        chk("rst_id_bus", {32'd0, mem_to_id_bus}, 70'd0);
        #9 resetn = 1'b1;

        // Byte and half loads
        do_load("ldb_s", mk_bus(32'h100, 1'b1, 1'b1, 5'd3, 32'h1003, 2'd3, 1'b1, 1'b0, 1'b0),
                32'h80FF_1234, 32'hFFFF_FF80);
        chk("ldb_id_bus", {32'd0, mem_to_id_bus}, {32'd0, 1'b1, 5'd3, 32'hFFFF_FF80});
        do_load("ldb_u", mk_bus(32'h104, 1'b1, 1'b1, 5'd3, 32'h1003, 2'd3, 1'b1, 1'b0, 1'b1),
                32'h80FF_1234, 32'h0000_0080);
        do_load("ldb_lo1", mk_bus(32'h108, 1'b1, 1'b1, 5'd4, 32'h1001, 2'd1, 1'b1, 1'b0, 1'b0),
                32'h80FF_1234, 32'h0000_0012);
        do_load("ldh_s", mk_bus(32'h10C, 1'b1, 1'b1, 5'd4, 32'h1002, 2'd2, 1'b0, 1'b1, 1'b0),
                32'h9ABC_5678, 32'hFFFF_9ABC);
        do_load("ldh_u", mk_bus(32'h110, 1'b1, 1'b1, 5'd4, 32'h1000, 2'd0, 1'b0, 1'b1, 1'b1),
                32'h9ABC_5678, 32'h0000_5678);
        do_load("ldh_lo1", mk_bus(32'h114, 1'b1, 1'b1, 5'd4, 32'h1001, 2'd1, 1'b0, 1'b1, 1'b0),
                32'h0000_8000, 32'hFFFF_8000);

        // Store passes alu_result, rf_we low on both buses
        do_load("st_res", mk_bus(32'h118, 1'b0, 1'b0, 5'd9, 32'h2000, 2'd0, 1'b0, 1'b0, 1'b0),
                32'hFFFF_FFFF, 32'h0000_2000);
        chk("st_wb_we", {69'd0, mem_to_wb_bus[37]}, 70'd0);
        chk("st_id_we", {69'd0, mem_to_id_bus[37]}, 70'd0);

        // Word load held across a 3-cycle WB stall while RAM data changes
        @(posedge clk); #1;
        wb_allowin      = 1'b0;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h300, 1'b1, 1'b1, 5'd7, 32'h4000, 2'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        ex_to_mem_bus   = mk_bus(32'h304, 1'b0, 1'b1, 5'd5, 32'h42, 2'd0, 1'b0, 1'b0, 1'b0);
        data_sram_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("stall_c1_res", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h1111_1111});
        chk("stall_allowin", {69'd0, mem_allowin}, 70'd0);
        @(posedge clk); #1;
        data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stall_c2_res", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h1111_1111});
        chk("stall_c2_valid", {69'd0, mem_to_wb_valid}, 70'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_c3_res", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h1111_1111});
        chk("stall_c3_pc", {38'd0, mem_to_wb_bus[69:38]}, {38'd0, 32'h300});
        @(posedge clk); #1;
        wb_allowin = 1'b1;
        @(negedge clk);
        chk("release_res", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h1111_1111});
        chk("release_allowin", {69'd0, mem_allowin}, 70'd1);

        // Back-to-back adds drain and accept on the same edge
        @(posedge clk); #1;
        ex_to_mem_bus = mk_bus(32'h308, 1'b0, 1'b1, 5'd6, 32'h43, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("add1_id_bus", {32'd0, mem_to_id_bus}, {32'd0, 1'b1, 5'd5, 32'h42});
        chk("add1_valid", {69'd0, mem_to_wb_valid}, 70'd1);
        @(posedge clk); #1;
        ex_to_mem_valid = 1'b0;
        @(negedge clk);
        chk("add2_id_bus", {32'd0, mem_to_id_bus}, {32'd0, 1'b1, 5'd6, 32'h43});
        chk("add2_pc", {38'd0, mem_to_wb_bus[69:38]}, {38'd0, 32'h308});
        @(posedge clk); #1;
        @(negedge clk);
        chk("drained_valid", {69'd0, mem_to_wb_valid}, 70'd0);

        // Asynchronous reset mid-stall, then a fresh accept
        @(posedge clk); #1;
        wb_allowin      = 1'b0;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h400, 1'b1, 1'b1, 5'd8, 32'h5000, 2'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        ex_to_mem_valid = 1'b0;
        data_sram_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("pre_rst_valid", {69'd0, mem_to_wb_valid}, 70'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_valid", {69'd0, mem_to_wb_valid}, 70'd0);
        chk("async_rst_id_we", {69'd0, mem_to_id_bus[37]}, 70'd0);
        chk("async_rst_allowin", {69'd0, mem_allowin}, 70'd1);
        chk("async_rst_wb_bus", mem_to_wb_bus, 70'd0);
        @(posedge clk); #1;
        resetn     = 1'b1;
        wb_allowin = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {69'd0, mem_to_wb_valid}, 70'd0);
        do_load("fresh_ldw", mk_bus(32'h500, 1'b1, 1'b1, 5'd10, 32'h6000, 2'd0, 1'b0, 1'b0, 1'b0),
                32'hCAFE_F00D, 32'hCAFE_F00D);
        chk("fresh_id_bus", {32'd0, mem_to_id_bus}, {32'd0, 1'b1, 5'd10, 32'hCAFE_F00D});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 No parameters; all widths SHALL be fixed.
- REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
- REQ-003 resetn  in  1  asynchronous, active-low reset.
- REQ-004 ex_to_mem_valid  in  1  upstream payload valid.
- REQ-005 ex_to_mem_bus  in  108  {pc[31:0], res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0], rkd_value[31:0], addr_lo[1:0], op_b, op_h, op_u}, MSB first.
- REQ-006 mem_allowin  out  1  stage accepts new payload this cycle.
- REQ-007 data_sram_rdata  in  32  synchronous-RAM read data, valid the cycle after the address was presented upstream.
- REQ-008 wb_allowin  in  1  downstream accepts.
- REQ-009 mem_to_wb_valid  out  1  payload valid to WB.
- REQ-010 mem_to_wb_bus  out  70  {pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}.
- REQ-011 mem_to_id_bus  out  38  {rf_we, rf_waddr[4:0], final_result[31:0]}, used for hazard detection and forwarding.

Function
- REQ-012 mem_ready_go SHALL be constant 1; mem_allowin = ~mem_valid | (wb_allowin & mem_ready_go); mem_to_wb_valid = mem_valid & mem_ready_go.
- REQ-013 When mem_allowin=1, mem_valid SHALL load ex_to_mem_valid at the next edge; otherwise it SHALL hold.
- REQ-014 Payload registers SHALL load ex_to_mem_bus only when ex_to_mem_valid & mem_allowin; otherwise they SHALL hold.
- REQ-015 first_cyc flag SHALL be set on each accepted payload and cleared at the following edge.
- REQ-016 rdata_hold SHALL capture data_sram_rdata at the edge ending a cycle with mem_valid & first_cyc; eff_rdata = first_cyc ? data_sram_rdata : rdata_hold, so a WB stall never loses the load data when upstream issues a new RAM access.
- REQ-017 Byte load (op_b): byte = eff_rdata[8*addr_lo+7 : 8*addr_lo]; extended to 32 bits with zeros if op_u, otherwise sign-extended.
- REQ-018 Half load (op_h): half = addr_lo[1] ? eff_rdata[31:16] : eff_rdata[15:0]; zero- or sign-extended by op_u; addr_lo[0] SHALL be ignored (no alignment exception).
- REQ-019 Word load (neither op_b nor op_h): load_result = eff_rdata.
- REQ-020 final_result = res_from_mem ? load_result : alu_result.
- REQ-021 rf_we on both output buses SHALL be gated with mem_valid; rf_waddr and final_result SHALL pass unmodified.
- REQ-022 Simultaneous wb_allowin=1 and ex_to_mem_valid=1 SHALL drain the old payload and accept the new one in the same edge, without a bubble.
- REQ-023 Back-pressure: with mem_valid=1 and wb_allowin=0, all registers except rdata_hold capture (REQ-016) SHALL hold and the outputs SHALL remain stable.
- REQ-024 Stores and non-memory ops SHALL pass alu_result through; rkd_value SHALL be carried but unused.

Reset
- REQ-025 Assertion of resetn=0 SHALL immediately clear mem_valid, first_cyc, all payload registers and rdata_hold to 0, independent of clk.
- REQ-026 During reset, outputs SHALL be mem_allowin=1, mem_to_wb_valid=0, and both buses all-zero.
- REQ-027 Reset asserted mid-stall SHALL discard the held payload; the first post-reset accept SHALL behave as a fresh accept.

Structure
- REQ-028 Bus widths (108/70/38) and field offsets SHALL be defined as constants in the shared pipeline package used by all stages.
- REQ-029 Load alignment/extension SHALL be a combinational sub-module named load_align (inputs eff_rdata, addr_lo, op_b, op_h, op_u; output load_result).

Verification
- REQ-030 ld.b, addr_lo=3, rdata=0x80FF_1234, op_u=0 -> final_result=0xFFFF_FF80; with op_u=1 -> 0x0000_0080.
- REQ-031 ld.h, addr_lo=2, rdata=0x9ABC_5678, op_u=0 -> 0xFFFF_9ABC; addr_lo=0 with op_u=1 -> 0x0000_5678.
- REQ-032 ld.w accepted, wb_allowin=0 for 3 cycles while data_sram_rdata changes from 0x1111_1111 to 0xDEAD_BEEF after cycle 1 -> final_result stays 0x1111_1111 and is delivered on release.
- REQ-033 add (res_from_mem=0, alu_result=0x0000_0042, rf_we=1, waddr=5) back-to-back with wb_allowin=1 -> mem_to_id_bus={1,5,0x42} one cycle after accept; no bubble between consecutive payloads.
- REQ-034 resetn pulled low between edges while mem_valid=1 -> mem_to_wb_valid=0 and mem_to_id_bus rf_we=0 immediately, before the next clk edge.
- REQ-035 Store (res_from_mem=0, rf_we=0) -> mem_to_wb_valid=1 and rf_we=0 on both buses.
